// File: rtl/line_memory_responder_if.sv
// rtl/line_memory_responder_if.sv - request/response bundle between cache controller and line memory
interface line_memory_responder_if #(
    parameter int BLOCK_SIZE = 16
);
    logic                    is_input_valid;
    logic [31:0]             addr;
    logic                    mem_read;
    logic                    mem_write;
    logic [BLOCK_SIZE*8-1:0] din;
    logic                    is_output_valid;
    logic [BLOCK_SIZE*8-1:0] dout;
    logic                    mem_ready;
    logic [31:0]             read_count;
    logic [31:0]             write_count;

    // Cache controller side: issues requests, observes completions.
    modport master (
        output is_input_valid, addr, mem_read, mem_write, din,
        input  is_output_valid, dout, mem_ready, read_count, write_count
    );

    // Responder side.
    modport slave (
        input  is_input_valid, addr, mem_read, mem_write, din,
        output is_output_valid, dout, mem_ready, read_count, write_count
    );
endinterface

// File: rtl/line_memory_responder.sv
// rtl/line_memory_responder.sv - fixed-latency full-line backing store for cache refill/write-back
module line_memory_responder #(
    parameter int BLOCK_SIZE = 16,
    parameter int MEM_DEPTH  = 256,
    parameter int DELAY      = 50
) (
    input  logic                    clk,
    input  logic                    reset,
    line_memory_responder_if.slave  bus
);

    localparam int LINE_W = BLOCK_SIZE * 8;
    // Word-offset bits inside a line; these address bits never select a line.
    localparam int W      = $clog2(BLOCK_SIZE / 4);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CNT_W  = (DELAY > 1) ? $clog2(DELAY) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   line_q;
    logic               op_read_q;
    logic [LINE_W-1:0]  din_q;
    logic [LINE_W-1:0]  mem [MEM_DEPTH];

    logic [IDX_W-1:0]   req_line;
    logic               req_ok;
    logic               accept;
    logic               complete;
    logic               ready_c;

    logic               out_valid_q;
    logic [LINE_W-1:0]  dout_q;
    logic [31:0]        read_count_q;
    logic [31:0]        write_count_q;

    // Line index wraps modulo MEM_DEPTH simply by truncating the shifted word address.
    assign req_line = IDX_W'(bus.addr >> W);

    // A request is well-formed only with exactly one op bit set.
    assign req_ok = bus.is_input_valid && (bus.mem_read ^ bus.mem_write);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE waits for a valid request, BUSY runs out the latency counter.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_ok) state_next = BUSY;
            BUSY:    if (cnt == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/strobe decode from the current state.
    always_comb begin
        ready_c  = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                accept  = req_ok;
            end
            BUSY: begin
                complete = (cnt == '0);
            end
            default: begin
                ready_c = 1'b0;
            end
        endcase
    end

    // Request latch and latency counter; inputs are only looked at on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            line_q    <= '0;
            op_read_q <= 1'b0;
            din_q     <= '0;
        end else if (accept) begin
            cnt       <= CNT_W'(DELAY - 1);
            line_q    <= req_line;
            op_read_q <= bus.mem_read;
            din_q     <= bus.din;
        end else if (state == BUSY && !complete) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Line array: cleared on reset, committed only when a write completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (complete && !op_read_q) begin
            mem[line_q] <= din_q;
        end
    end

    // Completion side effects: read data/pulse and the two op counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            dout_q        <= '0;
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            out_valid_q <= complete && op_read_q;
            if (complete && op_read_q) begin
                dout_q       <= mem[line_q];
                read_count_q <= read_count_q + 32'd1;
            end
            if (complete && !op_read_q) begin
                write_count_q <= write_count_q + 32'd1;
            end
        end
    end

    assign bus.mem_ready       = ready_c;
    assign bus.is_output_valid = out_valid_q;
    assign bus.dout            = dout_q;
    assign bus.read_count      = read_count_q;
    assign bus.write_count     = write_count_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// tb/tb_line_memory_responder.sv - directed bench with timestamp-based reference model
module tb_line_memory_responder;

    localparam int BS    = 16;
    localparam int DEPTH = 16;
    localparam int DLY   = 4;

    localparam logic [127:0] D_A  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D_AA = {16{8'hAA}};
    localparam logic [127:0] D_55 = {16{8'h55}};
    localparam logic [127:0] D_X  = 128'hDEADBEEF_00000005_CAFEF00D_12345678;
    localparam logic [127:0] D_Y  = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
    localparam logic [127:0] D_9  = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
    localparam logic [127:0] D_1  = 128'h11111111_22222222_33333333_44444444;

    logic clk = 1'b0;
    logic reset;

    line_memory_responder_if #(.BLOCK_SIZE(BS)) bus ();

    line_memory_responder #(
        .BLOCK_SIZE(BS),
        .MEM_DEPTH (DEPTH),
        .DELAY     (DLY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: an accepted op completes DLY edges after the accept edge.
    longint       cyc = 0;
    bit           m_busy;
    longint       m_done_at;
    bit           m_rd;
    int           m_line;
    logic [127:0] m_data;
    logic [127:0] m_mem [DEPTH];
    bit           m_valid;
    logic [127:0] m_dout;
    logic [31:0]  m_rc;
    logic [31:0]  m_wc;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_dout  <= '0;
            m_rc    <= '0;
            m_wc    <= '0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
        end else begin
            m_valid <= 1'b0;
            if (m_busy && cyc == m_done_at) begin
                m_busy <= 1'b0;
                if (m_rd) begin
                    m_dout  <= m_mem[m_line];
                    m_valid <= 1'b1;
                    m_rc    <= m_rc + 1;
                end else begin
                    m_mem[m_line] <= m_data;
                    m_wc          <= m_wc + 1;
                end
            end else if (!m_busy && bus.is_input_valid && (bus.mem_read != bus.mem_write)) begin
                m_busy    <= 1'b1;
                m_done_at <= cyc + DLY;
                m_rd      <= bus.mem_read;
                m_line    <= int'(bus.addr[31:2] % DEPTH);
                m_data    <= bus.din;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_ready", {127'd0, bus.mem_ready}, {127'd0, !m_busy});
            check("mdl_valid", {127'd0, bus.is_output_valid}, {127'd0, m_valid});
            check("mdl_dout", bus.dout, m_dout);
            check("mdl_rcnt", {96'd0, bus.read_count}, {96'd0, m_rc});
            check("mdl_wcnt", {96'd0, bus.write_count}, {96'd0, m_wc});
        end
    end

    // Pulse log for latency/spacing checks.
    int           ncyc = 0;
    int           pulse_cyc[$];
    logic [127:0] pulse_dat[$];

    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (chk_en && bus.is_output_valid) begin
            pulse_cyc.push_back(ncyc);
            pulse_dat.push_back(bus.dout);
        end
    end

    task automatic idle_inputs();
        bus.is_input_valid = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
    endtask

    // Called at a negedge with mem_ready high; returns at the negedge after the accept edge.
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] a, input logic [127:0] d);
        bus.is_input_valid = 1'b1;
        bus.mem_read       = rd;
        bus.mem_write      = wr;
        bus.addr           = a;
        bus.din            = d;
        @(negedge clk);
        idle_inputs();
    endtask

    // Waits (bounded) for mem_ready; returns the number of negedges it was seen low.
    task automatic wait_idle(output int low);
        low = 0;
        while (!bus.mem_ready && low < 20) begin
            low++;
            @(negedge clk);
        end
        if (low >= 20) check("ready_timeout", 128'd0, 128'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int low;

    initial begin
        reset = 1'b1;
        bus.addr = '0;
        bus.din  = '0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        // 1: reset state and read of a cleared line
        check("rst_ready", {127'd0, bus.mem_ready}, 128'd1);
        check("rst_valid", {127'd0, bus.is_output_valid}, 128'd0);
        check("rst_dout", bus.dout, 128'd0);
        check("rst_rcnt", {96'd0, bus.read_count}, 128'd0);
        check("rst_wcnt", {96'd0, bus.write_count}, 128'd0);
        do_op(1, 0, 32'h00, '0);
        wait_idle(low);
        check("s1_latency", low, 4);
        check("s1_valid", {127'd0, bus.is_output_valid}, 128'd1);
        check("s1_dout", bus.dout, 128'd0);
        @(negedge clk);

        // 2: write then read through a different word offset of the same line
        do_op(0, 1, 32'h24, D_A);
        wait_idle(low);
        check("s2_wr_busy", low, 4);
        check("s2_wcnt", {96'd0, bus.write_count}, 128'd1);
        check("s2_wr_novalid", {127'd0, bus.is_output_valid}, 128'd0);
        do_op(1, 0, 32'h27, 128'd0);
        wait_idle(low);
        check("s2_rd_busy", low, 4);
        check("s2_valid", {127'd0, bus.is_output_valid}, 128'd1);
        check("s2_dout", bus.dout, D_A);
        check("s2_rcnt", {96'd0, bus.read_count}, 128'd2);
        @(negedge clk);
        check("s2_pulse_end", {127'd0, bus.is_output_valid}, 128'd0);
        check("s2_dout_hold", bus.dout, D_A);

        // 3: wrap-around of line index
        do_op(0, 1, 32'h04, D_AA);
        wait_idle(low);
        do_op(1, 0, 32'h44, 128'd0);
        wait_idle(low);
        check("s3_dout", bus.dout, D_AA);
        @(negedge clk);

        // 4: malformed request ignored, request during BUSY dropped
        bus.is_input_valid = 1'b1;
        bus.mem_read       = 1'b1;
        bus.mem_write      = 1'b1;
        bus.addr           = 32'h08;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("s4_both_ready", {127'd0, bus.mem_ready}, 128'd1);
        end
        idle_inputs();
        do_op(0, 1, 32'h14, D_X);
        bus.is_input_valid = 1'b1;
        bus.mem_write      = 1'b1;
        bus.addr           = 32'h30;
        bus.din            = D_Y;
        @(negedge clk);
        @(negedge clk);
        idle_inputs();
        wait_idle(low);
        check("s4_wcnt", {96'd0, bus.write_count}, 128'd3);
        do_op(1, 0, 32'h30, 128'd0);
        wait_idle(low);
        check("s4_dropped_line", bus.dout, 128'd0);
        do_op(1, 0, 32'h14, 128'd0);
        wait_idle(low);
        check("s4_latched_data", bus.dout, D_X);
        @(negedge clk);

        // 5: reset two cycles after a write is accepted
        do_reset();
        do_op(0, 1, 32'h0C, D_55);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("s5_wcnt", {96'd0, bus.write_count}, 128'd0);
        check("s5_ready", {127'd0, bus.mem_ready}, 128'd1);
        do_op(1, 0, 32'h0C, 128'd0);
        wait_idle(low);
        check("s5_dout", bus.dout, 128'd0);
        check("s5_rcnt", {96'd0, bus.read_count}, 128'd1);
        @(negedge clk);

        // 6: back-to-back reads, second issued during the first pulse
        do_op(0, 1, 32'h24, D_9);
        wait_idle(low);
        do_op(0, 1, 32'h04, D_1);
        wait_idle(low);
        pulse_cyc.delete();
        pulse_dat.delete();
        do_op(1, 0, 32'h24, 128'd0);
        wait_idle(low);
        do_op(1, 0, 32'h04, 128'd0);
        check("s6_accepted", {127'd0, bus.mem_ready}, 128'd0);
        wait_idle(low);
        @(negedge clk);
        #1;
        check("s6_npulses", pulse_cyc.size(), 2);
        if (pulse_cyc.size() == 2) begin
            check("s6_spacing", pulse_cyc[1] - pulse_cyc[0], 5);
            check("s6_dat0", pulse_dat[0], D_9);
            check("s6_dat1", pulse_dat[1], D_1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
